// File: rtl/stepper_pkg.sv
// Shared types and helpers for the N-axis DDA stepper pulse generator.
package stepper_pkg;

  localparam int unsigned NumAxesDflt  = 3;
  localparam int unsigned StepBitsDflt = 8;
  localparam int unsigned WideBits     = 64;

  typedef enum logic [1:0] {StIdle, StSetup, StStepHi, StStepLo} state_t;

  typedef logic [NumAxesDflt-1:0]         axis_vec_t;
  typedef logic signed [StepBitsDflt-1:0] step_t;
  typedef logic [WideBits-1:0]            wide_t;

  // Magnitude of a sign-extended count; callers narrow to STEP_BITS, so the
  // most-negative count keeps its full magnitude.
  function automatic wide_t abs_wide(input wide_t v);
    return v[WideBits-1] ? (~v + wide_t'(1)) : v;
  endfunction

endpackage

// File: rtl/stepper_dda_axis.sv
// One Bresenham interpolation axis: latches magnitude/direction, steps on each advance strobe.
module stepper_dda_axis #(
  parameter int unsigned STEP_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [STEP_BITS-1:0] cmd_step,
  input  logic                 first,
  input  logic                 advance,
  input  logic                 clr_step,
  input  logic [STEP_BITS-1:0] major,
  output logic [STEP_BITS-1:0] abs_mag,
  output logic                 dir,
  output logic                 step
);
  import stepper_pkg::*;

  logic [STEP_BITS-1:0] abs_q;
  logic                 dir_q;
  logic                 step_q;
  logic [STEP_BITS:0]   err_q;
  logic [STEP_BITS:0]   major_ext;
  logic [STEP_BITS:0]   err_base;
  logic [STEP_BITS:0]   sum;

  assign major_ext = {1'b0, major};
  // The first step of a move starts from the half-major seed instead of the stored error.
  assign err_base  = first ? (major_ext >> 1) : err_q;
  assign sum       = err_base + {1'b0, abs_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      abs_q  <= '0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      err_q  <= '0;
    end else begin
      if (load) begin
        abs_q <= STEP_BITS'(abs_wide(wide_t'($signed(cmd_step))));
        dir_q <= cmd_step[STEP_BITS-1];
      end
      if (advance) begin
        step_q <= (sum >= major_ext);
        err_q  <= (sum >= major_ext) ? (sum - major_ext) : sum;
      end else if (clr_step) begin
        step_q <= 1'b0;
      end
    end
  end

  assign abs_mag = abs_q;
  assign dir     = dir_q;
  assign step    = step_q;

endmodule

// File: rtl/stepper_interp_nd.sv
// N-axis stepper pulse generator: command handshake, pulse-phase FSM and major-axis reduction.
module stepper_interp_nd #(
  parameter int unsigned NUM_AXES   = 3,
  parameter int unsigned STEP_BITS  = 8,
  parameter int unsigned TICK_BITS  = 8,
  parameter int unsigned HIGH_TICKS = 4,
  parameter int unsigned LOW_TICKS  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clk_en,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [NUM_AXES*STEP_BITS-1:0] cmd_steps,
  input  logic                          abort,
  output logic [NUM_AXES-1:0]           step_out,
  output logic [NUM_AXES-1:0]           dir_out,
  output logic                          busy,
  output logic                          done
);
  import stepper_pkg::*;

  localparam logic [TICK_BITS-1:0] HiLast = TICK_BITS'(HIGH_TICKS - 1);
  localparam logic [TICK_BITS-1:0] LoLast = TICK_BITS'(LOW_TICKS - 1);

  state_t               state_q, state_d;
  logic [TICK_BITS-1:0] tick_q, tick_d;
  logic [STEP_BITS-1:0] step_cnt_q, step_cnt_d;
  logic                 abort_q, abort_d;
  logic                 done_q, done_d;
  logic                 load, first, advance, clr_step, abort_seen;
  logic [STEP_BITS-1:0] major;
  logic [STEP_BITS-1:0] abs_vec [NUM_AXES];

  for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
    stepper_dda_axis #(
      .STEP_BITS(STEP_BITS)
    ) u_axis (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .cmd_step (cmd_steps[i*STEP_BITS +: STEP_BITS]),
      .first    (first),
      .advance  (advance),
      .clr_step (clr_step),
      .major    (major),
      .abs_mag  (abs_vec[i]),
      .dir      (dir_out[i]),
      .step     (step_out[i])
    );
  end

  always_comb begin
    major = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      if (abs_vec[i] > major) major = abs_vec[i];
    end
  end

  assign abort_seen = abort_q | abort;

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    step_cnt_d = step_cnt_q;
    abort_d    = abort_q;
    done_d     = 1'b0;
    load       = 1'b0;
    first      = 1'b0;
    advance    = 1'b0;
    clr_step   = 1'b0;
    if (state_q != StIdle && abort) abort_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        abort_d = 1'b0;
        if (cmd_valid) begin
          load    = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (clk_en) begin
          tick_d     = '0;
          step_cnt_d = '0;
          if (major == '0 || abort_seen) begin
            state_d = StIdle;
            done_d  = 1'b1;
            abort_d = 1'b0;
          end else begin
            state_d    = StStepHi;
            first      = 1'b1;
            advance    = 1'b1;
            step_cnt_d = STEP_BITS'(1);
          end
        end
      end
      StStepHi: begin
        if (clk_en) begin
          if (tick_q == HiLast) begin
            tick_d   = '0;
            clr_step = 1'b1;
            state_d  = StStepLo;
          end else begin
            tick_d = tick_q + TICK_BITS'(1);
          end
        end
      end
      StStepLo: begin
        if (clk_en) begin
          if (tick_q == LoLast) begin
            tick_d = '0;
            if (step_cnt_q == major || abort_seen) begin
              state_d = StIdle;
              done_d  = 1'b1;
              abort_d = 1'b0;
            end else begin
              state_d    = StStepHi;
              advance    = 1'b1;
              step_cnt_d = step_cnt_q + STEP_BITS'(1);
            end
          end else begin
            tick_d = tick_q + TICK_BITS'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      tick_q     <= '0;
      step_cnt_q <= '0;
      abort_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      step_cnt_q <= step_cnt_d;
      abort_q    <= abort_d;
      done_q     <= done_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

endmodule

// File: tb/tb_stepper_interp_nd.sv
// Directed, table-driven bench for stepper_interp_nd with HIGH_TICKS=2, LOW_TICKS=3.
module tb_stepper_interp_nd;
  localparam int NA = 3;
  localparam int SB = 8;
  localparam int H  = 2;
  localparam int L  = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             clk_en;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [NA*SB-1:0] cmd_steps;
  logic             abort;
  logic [NA-1:0]    step_out;
  logic [NA-1:0]    dir_out;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [23:0] steps;
    int          p;
    int          abort_at;
    int          cnt0;
    int          cnt1;
    int          cnt2;
    logic [2:0]  dir;
    int          mask1;
    int          delay;
  } vec_t;

  vec_t vecs[6];

  stepper_interp_nd #(
    .NUM_AXES   (NA),
    .STEP_BITS  (SB),
    .TICK_BITS  (8),
    .HIGH_TICKS (H),
    .LOW_TICKS  (L)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_steps (cmd_steps),
    .abort     (abort),
    .step_out  (step_out),
    .dir_out   (dir_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string what, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", what, act, exp);
    end
  endtask

  // Runs one move; clk_en is high on every p-th clock. Counts rising edges per
  // axis, records which major steps axis1 fired on, and times done from the first pulse.
  task automatic check_move(input vec_t v);
    int         cnt[3];
    int         mask1, step_idx, hi_len, hiw_bad, c1, cyc;
    logic [2:0] prev, rise, dir_seen;
    bit         fin;
    cnt = '{0, 0, 0};
    mask1 = 0; step_idx = 0; hi_len = 0; hiw_bad = 0; c1 = -1; cyc = 0;
    prev = '0; fin = 1'b0;
    @(negedge clk);
    cmd_steps = v.steps;
    cmd_valid = 1'b1;
    clk_en    = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check({v.name, " accepted busy"}, int'(busy), 1);
    dir_seen = dir_out;
    while (!fin && cyc < 4000) begin
      clk_en = ((cyc % v.p) == 0);
      @(negedge clk);
      cyc++;
      abort = 1'b0;
      rise = step_out & ~prev;
      if (|rise) begin
        step_idx++;
        if (c1 < 0) c1 = cyc;
      end
      for (int i = 0; i < 3; i++) if (rise[i]) cnt[i]++;
      if (rise[1] && step_idx <= 32) mask1 |= (1 << (step_idx - 1));
      if (|step_out) hi_len++;
      else if (|prev) begin
        if (hi_len != H * v.p) hiw_bad++;
        hi_len = 0;
      end
      if (v.abort_at > 0 && (|rise) && step_idx == v.abort_at) abort = 1'b1;
      if (done) fin = 1'b1;
      prev = step_out;
    end
    clk_en = 1'b1;
    abort  = 1'b0;
    check({v.name, " done seen"}, int'(fin), 1);
    check({v.name, " axis0 pulses"}, cnt[0], v.cnt0);
    check({v.name, " axis1 pulses"}, cnt[1], v.cnt1);
    check({v.name, " axis2 pulses"}, cnt[2], v.cnt2);
    check({v.name, " dir_out"}, int'(dir_seen), int'(v.dir));
    check({v.name, " axis1 step mask"}, mask1, v.mask1);
    check({v.name, " bad high widths"}, hiw_bad, 0);
    check({v.name, " done delay"}, cyc - c1, v.delay);
    @(negedge clk);
    check({v.name, " done one clk"}, int'(done), 0);
    check({v.name, " ready after"}, int'(cmd_ready), 1);
  endtask

  initial begin
    vecs[0] = '{"m6_m3_0",     24'h00FD06, 1, 0, 6,   3, 0, 3'b010, 'h15, 30};
    vecs[1] = '{"neg128",      24'h000080, 1, 0, 128, 0, 0, 3'b001, 0,    640};
    vecs[2] = '{"m6_m3_0_en3", 24'h00FD06, 3, 0, 6,   3, 0, 3'b010, 'h15, 90};
    vecs[3] = '{"abort_p2",    24'hFF02FB, 1, 2, 2,   1, 0, 3'b101, 'h2,  10};
    vecs[4] = '{"m3_7_m7",     24'hF90703, 1, 0, 3,   7, 7, 3'b100, 'h7F, 35};
    vecs[5] = '{"m1_m1_en2",   24'h00FF01, 2, 0, 1,   1, 0, 3'b010, 'h1,  10};

    reset = 1'b0; clk_en = 1'b0; cmd_valid = 1'b0; abort = 1'b0; cmd_steps = '0;
    repeat (2) @(negedge clk);
    check("reset step_out", int'(step_out), 0);
    check("reset dir_out", int'(dir_out), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset cmd_ready", int'(cmd_ready), 1);
    reset = 1'b1;
    @(negedge clk);

    // All-zero command: SETUP then straight back to IDLE with done.
    cmd_steps = '0; cmd_valid = 1'b1; clk_en = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("zero setup busy", int'(busy), 1);
    check("zero setup ready", int'(cmd_ready), 0);
    check("zero setup done", int'(done), 0);
    @(negedge clk);
    check("zero done", int'(done), 1);
    check("zero idle busy", int'(busy), 0);
    check("zero ready", int'(cmd_ready), 1);
    check("zero no step", int'(step_out), 0);
    @(negedge clk);
    check("zero done cleared", int'(done), 0);

    for (int k = 0; k < 6; k++) check_move(vecs[k]);

    // Reset in the middle of a high phase, then a clean (2,2,2) move.
    @(negedge clk);
    cmd_steps = 24'h0201FD; cmd_valid = 1'b1; clk_en = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && step_out == '0; i++) @(negedge clk);
    check("rst_mid first step", int'(step_out), 3'b101);
    check("rst_mid dir", int'(dir_out), 3'b001);
    #2 reset = 1'b0;
    #1;
    check("rst_mid step_out", int'(step_out), 0);
    check("rst_mid busy", int'(busy), 0);
    check("rst_mid dir_out", int'(dir_out), 0);
    check("rst_mid cmd_ready", int'(cmd_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    check_move('{"after_rst_222", 24'h020202, 1, 0, 2, 2, 2, 3'b000, 'h3, 10});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
